// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the M-stage data-memory responder.
//   DMEM_WORD_W   data word width
//   dmem_state_t  access FSM states (idle / waiting / completing)
//   is_misaligned byte-offset check used when DMEM_ALIGN_CHECK_EN is defined
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int unsigned DMEM_WORD_W = 32;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_WAIT,
      DM_DONE
   } dmem_state_t;

   function automatic logic is_misaligned(input logic [1:0] byte_off);
      return byte_off != 2'b00;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-addressed storage for the data-memory responder.
// Asynchronous read, synchronous write; contents are not reset.
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable for this edge
//   idx_i    in   word index (shared by read and write)
//   wdata_i  in   write data
//   rdata_o  out  combinational read data at idx_i
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   we_i,
   input  logic [IDX_W-1:0]       idx_i,
   input  logic [DMEM_WORD_W-1:0] wdata_i,
   output logic [DMEM_WORD_W-1:0] rdata_o
);

   logic [DMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// M-stage data-memory responder. Serves one load or store at a time with a
// fixed WAIT_STATES access latency and holds the pipeline via dmem_stall_m
// for exactly WAIT_STATES cycles per access.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_STATES  stall cycles per access (0..15, 0 = single cycle)
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high reset
//   mem_to_reg_m  in   load request
//   dmem_write_m  in   store request (never together with a load)
//   alu_out_m     in   byte address; upper bits beyond the array wrap
//   write_data_m  in   store data
//   read_data_m   out  load data, valid in the non-stalled cycle of a load
//   dmem_stall_m  out  hold F/D/X/M while an access is outstanding
//   misaligned_m  out  byte offset != 0 in the completing cycle
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned accesses are flagged,
//                        misaligned stores are suppressed and misaligned
//                        loads return 0; otherwise addr[1:0] is ignored and
//                        misaligned_m is tied low.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mem_to_reg_m,
   input  logic                   dmem_write_m,
   input  logic [31:0]            alu_out_m,
   input  logic [DMEM_WORD_W-1:0] write_data_m,
   output logic [DMEM_WORD_W-1:0] read_data_m,
   output logic                   dmem_stall_m,
   output logic                   misaligned_m
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned AW    = IDX_W + 2;
   localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   // Entering WAIT accounts for two of the stall cycles (the IDLE request
   // cycle and the final WAIT cycle), hence the -2 preload.
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 1) ? WAIT_STATES - 2 : 0);

   dmem_state_t             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q,   cnt_d;
   logic [AW-1:0]           addr_q,  addr_d;
   logic [DMEM_WORD_W-1:0]  data_q,  data_d;
   logic                    we_q,    we_d;

   logic                    req;
   logic                    in_idle;
   logic [AW-1:0]           acc_addr;
   logic [DMEM_WORD_W-1:0]  acc_data;
   logic                    acc_we;
   logic                    acc_load;
   logic                    completing;
   logic                    mis;
   logic                    arr_we;
   logic [DMEM_WORD_W-1:0]  arr_rdata;
   logic                    unused_addr;

   assign req     = mem_to_reg_m | dmem_write_m;
   assign in_idle = (state_q == DM_IDLE);

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = we_q;
      case (state_q)
         DM_IDLE: begin
            if (req && (WAIT_STATES != 0)) begin
               addr_d = alu_out_m[AW-1:0];
               data_d = write_data_m;
               we_d   = dmem_write_m;
               if (WAIT_STATES == 1) begin
                  state_d = DM_DONE;
               end else begin
                  state_d = DM_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         DM_WAIT: begin
            if (cnt_q == '0) begin
               state_d = DM_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DM_DONE: begin
            state_d = DM_IDLE;
         end
         default: begin
            state_d = DM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DM_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
      end
   end

   // ---------------------------------------------------------------- access view
   // IDLE serves the live M-stage request; WAIT/DONE serve the latched one.
   assign acc_addr   = in_idle ? alu_out_m[AW-1:0] : addr_q;
   assign acc_data   = in_idle ? write_data_m      : data_q;
   assign acc_we     = in_idle ? dmem_write_m      : we_q;
   assign acc_load   = in_idle ? mem_to_reg_m      : !we_q;
   assign completing = in_idle ? (req && (WAIT_STATES == 0)) : (state_q == DM_DONE);

`ifdef DMEM_ALIGN_CHECK_EN
   assign mis         = is_misaligned(acc_addr[1:0]);
   assign unused_addr = ^alu_out_m[31:AW];
`else
   assign mis         = 1'b0;
   assign unused_addr = ^{alu_out_m[31:AW], acc_addr[1:0]};
`endif

   // Gating with reset drops a store whose commit edge coincides with reset.
   assign arr_we = !reset && completing && acc_we && !mis;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .idx_i   (acc_addr[AW-1:2]),
      .wdata_i (acc_data),
      .rdata_o (arr_rdata)
   );

   // ---------------------------------------------------------------- outputs
   assign dmem_stall_m = !reset && ((in_idle && req && (WAIT_STATES != 0)) ||
                                    (state_q == DM_WAIT));
   assign misaligned_m = !reset && completing && mis;
   assign read_data_m  = (!reset && acc_load && !mis) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int NDUT = 3;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ld    [NDUT];
   logic        sw    [NDUT];
   logic [31:0] ad    [NDUT];
   logic [31:0] wd    [NDUT];
   logic [31:0] rd    [NDUT];
   logic        stall [NDUT];
   logic        mis   [NDUT];

   int unsigned ws_of [NDUT] = '{0, 2, 3};

   // Reference model: one word array per DUT, plus which words have been written.
   logic [31:0] ref_mem   [NDUT][64];
   bit          ref_known [NDUT][64];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset(reset), .mem_to_reg_m(ld[0]), .dmem_write_m(sw[0]),
      .alu_out_m(ad[0]), .write_data_m(wd[0]), .read_data_m(rd[0]),
      .dmem_stall_m(stall[0]), .misaligned_m(mis[0]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .reset(reset), .mem_to_reg_m(ld[1]), .dmem_write_m(sw[1]),
      .alu_out_m(ad[1]), .write_data_m(wd[1]), .read_data_m(rd[1]),
      .dmem_stall_m(stall[1]), .misaligned_m(mis[1]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset(reset), .mem_to_reg_m(ld[2]), .dmem_write_m(sw[2]),
      .alu_out_m(ad[2]), .write_data_m(wd[2]), .read_data_m(rd[2]),
      .dmem_stall_m(stall[2]), .misaligned_m(mis[2]));

   function automatic int ref_idx(input logic [31:0] a);
      return int'((a / 32'd4) % 32'd64);
   endfunction

   function automatic bit ref_mis(input logic [31:0] a);
      return ALIGN && ((a % 32'd4) != 0);
   endfunction

   function automatic void ref_store(input int d, input logic [31:0] a, input logic [31:0] data);
      if (!ref_mis(a)) begin
         ref_mem[d][ref_idx(a)]   = data;
         ref_known[d][ref_idx(a)] = 1'b1;
      end
   endfunction

   // Drives one access on DUT d starting just after a rising edge and returns
   // once it completes (just after the following rising edge, request dropped).
   task automatic access(input int d, input bit is_st, input logic [31:0] a,
                         input logic [31:0] data, input bit scramble,
                         output int stalls, output logic [31:0] rdat, output logic misf);
      bit done = 1'b0;
      ld[d] = !is_st; sw[d] = is_st; ad[d] = a; wd[d] = data;
      stalls = 0; rdat = '0; misf = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (stall[d] === 1'b1) begin
            stalls++;
            @(posedge clk); #1;
            if (scramble) begin
               ad[d] = $urandom;
               wd[d] = $urandom;
               if ($urandom_range(0, 1) == 1) begin
                  ld[d] = !ld[d];
                  sw[d] = !sw[d];
               end
            end
         end else begin
            rdat = rd[d];
            misf = mis[d];
            done = 1'b1;
            @(posedge clk); #1;
         end
      end
      ld[d] = 1'b0; sw[d] = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL access_timeout dut=%0d: got no completion, required completion within 40 cycles", d);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         ld[d] = 1'b1; sw[d] = 1'b0; ad[d] = 32'h10; wd[d] = '0;
      end
      repeat (2) begin
         @(negedge clk);
         for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (stall[d] !== 1'b0) begin n_fail++; $display("FAIL reset_stall dut=%0d: got %b required 0", d, stall[d]); end
            n_checks++;
            if (mis[d] !== 1'b0) begin n_fail++; $display("FAIL reset_mis dut=%0d: got %b required 0", d, mis[d]); end
            n_checks++;
            if (rd[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata dut=%0d: got %h required 0", d, rd[d]); end
         end
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int d = 0; d < NDUT; d++) ld[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         n_checks++;
         if (stall[d] !== 1'b0 || rd[d] !== 32'h0) begin
            n_fail++; $display("FAIL idle_after_reset dut=%0d: got stall=%b rdata=%h required 0/0", d, stall[d], rd[d]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ws2_store_load();
      int st; logic [31:0] r; logic m;
      access(1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, st, r, m);
      ref_store(1, 32'h10, 32'hDEADBEEF);
      n_checks++;
      if (st != 2) begin n_fail++; $display("FAIL ws2_store_stalls: got %0d required 2", st); end
      access(1, 1'b0, 32'h10, 32'h0, 1'b0, st, r, m);
      n_checks++;
      if (st != 2) begin n_fail++; $display("FAIL ws2_load_stalls: got %0d required 2", st); end
      n_checks++;
      if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ws2_load_data: got %h required deadbeef", r); end
   endtask

   task automatic test_ws0_consecutive();
      int st; logic [31:0] r; logic m;
      access(0, 1'b1, 32'h8, 32'h1234, 1'b0, st, r, m);
      ref_store(0, 32'h8, 32'h1234);
      n_checks++;
      if (st != 0) begin n_fail++; $display("FAIL ws0_store_stalls: got %0d required 0", st); end
      access(0, 1'b0, 32'h8, 32'h0, 1'b0, st, r, m);
      n_checks++;
      if (st != 0) begin n_fail++; $display("FAIL ws0_load_stalls: got %0d required 0", st); end
      n_checks++;
      if (r !== 32'h1234) begin n_fail++; $display("FAIL ws0_load_data: got %h required 00001234", r); end
   endtask

   task automatic test_latch_ws3();
      int st; logic [31:0] r; logic m;
      access(2, 1'b1, 32'h20, 32'hC0FFEE11, 1'b1, st, r, m);
      ref_store(2, 32'h20, 32'hC0FFEE11);
      n_checks++;
      if (st != 3) begin n_fail++; $display("FAIL ws3_store_stalls: got %0d required 3", st); end
      access(2, 1'b0, 32'h20, 32'h0, 1'b1, st, r, m);
      n_checks++;
      if (r !== 32'hC0FFEE11) begin n_fail++; $display("FAIL ws3_latched_data: got %h required c0ffee11", r); end
      n_checks++;
      if (st != 3) begin n_fail++; $display("FAIL ws3_load_stalls: got %0d required 3", st); end
   endtask

   task automatic test_reset_mid_access();
      int st; logic [31:0] r; logic m;
      access(1, 1'b1, 32'h4, 32'h11, 1'b0, st, r, m);
      ref_store(1, 32'h4, 32'h11);
      // skip=1 asserts reset in the WAIT cycle, skip=2 in the DONE cycle.
      for (int skip = 1; skip <= 2; skip++) begin
         ld[1] = 1'b0; sw[1] = 1'b1; ad[1] = 32'h4; wd[1] = 32'h55 + skip;
         @(negedge clk);
         n_checks++;
         if (stall[1] !== 1'b1) begin n_fail++; $display("FAIL midreset_stall_start skip=%0d: got %b required 1", skip, stall[1]); end
         repeat (skip) @(posedge clk);
         #1 reset = 1'b1;
         @(negedge clk);
         n_checks++;
         if (stall[1] !== 1'b0) begin n_fail++; $display("FAIL midreset_stall_in_reset skip=%0d: got %b required 0", skip, stall[1]); end
         @(posedge clk); #1;
         reset = 1'b0; sw[1] = 1'b0;
         @(negedge clk);
         n_checks++;
         if (stall[1] !== 1'b0) begin n_fail++; $display("FAIL midreset_stall_after skip=%0d: got %b required 0", skip, stall[1]); end
         @(posedge clk); #1;
         access(1, 1'b0, 32'h4, 32'h0, 1'b0, st, r, m);
         n_checks++;
         if (r !== 32'h11) begin n_fail++; $display("FAIL midreset_store_dropped skip=%0d: got %h required 00000011", skip, r); end
         n_checks++;
         if (st != 2) begin n_fail++; $display("FAIL midreset_next_stalls skip=%0d: got %0d required 2", skip, st); end
      end
   endtask

   task automatic test_alias();
      int st; logic [31:0] r; logic m;
      access(1, 1'b1, 32'h100, 32'hA5, 1'b0, st, r, m);
      ref_store(1, 32'h100, 32'hA5);
      access(1, 1'b0, 32'h0, 32'h0, 1'b0, st, r, m);
      n_checks++;
      if (r !== 32'hA5) begin n_fail++; $display("FAIL alias_ws2: got %h required 000000a5", r); end
      access(0, 1'b1, 32'h104, 32'h5A5A, 1'b0, st, r, m);
      ref_store(0, 32'h104, 32'h5A5A);
      access(0, 1'b0, 32'h4, 32'h0, 1'b0, st, r, m);
      n_checks++;
      if (r !== 32'h5A5A) begin n_fail++; $display("FAIL alias_ws0: got %h required 00005a5a", r); end
   endtask

   task automatic test_misalign();
      int st; logic [31:0] r; logic m; logic [31:0] exp;
      access(1, 1'b1, 32'h6, 32'hCAFE0001, 1'b0, st, r, m);
      ref_store(1, 32'h6, 32'hCAFE0001);
      n_checks++;
      if (m !== ALIGN) begin n_fail++; $display("FAIL mis_store_flag: got %b required %b", m, ALIGN); end
      n_checks++;
      if (st != 2) begin n_fail++; $display("FAIL mis_store_stalls: got %0d required 2", st); end
      access(1, 1'b0, 32'h4, 32'h0, 1'b0, st, r, m);
      n_checks++;
      if (r !== ref_mem[1][1]) begin n_fail++; $display("FAIL mis_word1: got %h required %h", r, ref_mem[1][1]); end
      access(1, 1'b0, 32'h6, 32'h0, 1'b0, st, r, m);
      exp = ALIGN ? 32'h0 : ref_mem[1][1];
      n_checks++;
      if (r !== exp) begin n_fail++; $display("FAIL mis_load_data: got %h required %h", r, exp); end
      n_checks++;
      if (m !== ALIGN) begin n_fail++; $display("FAIL mis_load_flag: got %b required %b", m, ALIGN); end
      access(0, 1'b0, 32'h9, 32'h0, 1'b0, st, r, m);
      n_checks++;
      if (m !== ALIGN) begin n_fail++; $display("FAIL mis_ws0_flag: got %b required %b", m, ALIGN); end
   endtask

   task automatic test_random();
      int st; logic [31:0] r; logic m;
      int d; bit is_st; bit scr; logic [31:0] a; logic [31:0] data; int idx;
      for (int i = 0; i < 60; i++) begin
         d     = int'($urandom_range(0, NDUT - 1));
         is_st = 1'($urandom_range(0, 1));
         a     = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
         data  = $urandom;
         scr   = (ws_of[d] > 0) && ($urandom_range(0, 1) == 1);
         access(d, is_st, a, data, scr, st, r, m);
         n_checks++;
         if (st != int'(ws_of[d])) begin n_fail++; $display("FAIL rnd_stalls i=%0d dut=%0d: got %0d required %0d", i, d, st, ws_of[d]); end
         n_checks++;
         if (m !== ref_mis(a)) begin n_fail++; $display("FAIL rnd_mis i=%0d dut=%0d addr=%h: got %b required %b", i, d, a, m, ref_mis(a)); end
         idx = ref_idx(a);
         if (is_st) begin
            ref_store(d, a, data);
         end else if (ref_mis(a)) begin
            n_checks++;
            if (r !== 32'h0) begin n_fail++; $display("FAIL rnd_mis_load i=%0d dut=%0d: got %h required 0", i, d, r); end
         end else if (ref_known[d][idx]) begin
            n_checks++;
            if (r !== ref_mem[d][idx]) begin n_fail++; $display("FAIL rnd_load i=%0d dut=%0d addr=%h: got %h required %h", i, d, a, r, ref_mem[d][idx]); end
         end
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            n_checks++;
            if (stall[d] !== 1'b0 || rd[d] !== 32'h0) begin
               n_fail++; $display("FAIL rnd_idle i=%0d dut=%0d: got stall=%b rdata=%h required 0/0", i, d, stall[d], rd[d]);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         ld[d] = 1'b0; sw[d] = 1'b0; ad[d] = '0; wd[d] = '0;
         for (int w = 0; w < 64; w++) begin
            ref_mem[d][w] = '0; ref_known[d][w] = 1'b0;
         end
      end
      test_reset();
      test_ws2_store_load();
      test_ws0_consecutive();
      test_latch_ws3();
      test_reset_mid_access();
      test_alias();
      test_misalign();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running at 200000, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
